// File: rtl/jtpinpon_objline.sv
// rtl/jtpinpon_objline.sv - object line renderer: ROM fetch, PROM colour lookup, double-buffered line
// Optional build macro JTPINPON_OBJ_KEEPFIRST_EN: the first opaque pixel written to a location wins.
module jtpinpon_objline #(
    parameter logic [7:0] HOFFSET = 8'd6
) (
    input  logic        rst_n,
    input  logic        clk,
    input  logic        pxl_cen,
    input  logic        cen2,
    input  logic        hinit_x,
    input  logic        LHBL,
    input  logic [8:0]  hdump,
    input  logic        draw,
    output logic        busy,
    input  logic [7:0]  code,
    input  logic [7:0]  xpos,
    input  logic [4:0]  pal,
    input  logic        hflip,
    input  logic        vflip,
    input  logic [3:0]  ysub,
    input  logic [3:0]  prog_data,
    input  logic [7:0]  prog_addr,
    input  logic        prog_en,
    output logic [11:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        rom_cs,
    input  logic        rom_ok,
    output logic [3:0]  pxl
);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

    state_t      state, state_nxt;
    logic [6:0]  code_l;
    logic [7:0]  xpos_l;
    logic [3:0]  pal_l;
    logic        hflip_l, vflip_l;
    logic [3:0]  ysub_l;
    logic        half;
    logic [2:0]  cnt;
    logic [31:0] data_l;
    logic        bank_sel;
    logic        accept, ld_data, wr_pix;

    logic [3:0]  prom  [256];
    logic [3:0]  lbuf0 [256];
    logic [3:0]  lbuf1 [256];

    logic        unused_bits;
    assign unused_bits = ^{hdump[8], code[7], pal[4]};

    logic [3:0]  vr;
    assign vr       = ysub_l ^ {4{vflip_l}};
    assign rom_addr = {code_l, vr[3], half ^ hflip_l, vr[2:0]};
    assign busy     = (state != IDLE);
    // hinit_x cuts the ROM request in the same cycle, ahead of the abort edge
    assign rom_cs   = (state == FETCH) && !hinit_x;
    assign accept   = (state == IDLE) && cen2 && draw;

    always_comb begin
        state_nxt = state;
        ld_data   = 1'b0;
        wr_pix    = 1'b0;
        case (state)
            IDLE:  if (accept) state_nxt = FETCH;
            FETCH: begin
                if (hinit_x) state_nxt = IDLE;
                else if (rom_ok) begin
                    ld_data   = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (hinit_x) state_nxt = IDLE;
                else begin
                    wr_pix = 1'b1;
                    if (cnt == 3'd7) state_nxt = half ? IDLE : FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_l   <= '0;
            xpos_l   <= '0;
            pal_l    <= '0;
            hflip_l  <= 1'b0;
            vflip_l  <= 1'b0;
            ysub_l   <= '0;
            half     <= 1'b0;
            cnt      <= '0;
            data_l   <= '0;
            bank_sel <= 1'b0;
        end else begin
            if (hinit_x && cen2) bank_sel <= ~bank_sel;
            if (accept) begin
                code_l  <= code[6:0];
                xpos_l  <= xpos;
                pal_l   <= pal[3:0];
                hflip_l <= hflip;
                vflip_l <= vflip;
                ysub_l  <= ysub;
                half    <= 1'b0;
                cnt     <= '0;
            end
            if (ld_data) begin
                data_l <= rom_data;
                cnt    <= '0;
            end
            if (wr_pix) begin
                cnt <= cnt + 3'd1;
                if (cnt == 3'd7) half <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (prog_en) prom[prog_addr] <= prog_data;
    end

    // with hflip the nibbles of a fetch are emitted 7..0
    logic [2:0] k;
    logic [3:0] pix, colour, draw_cur;
    logic [8:0] wr_x;
    logic       keep_ok, wr_en, rd_en;
    logic [7:0] rd_addr;
    logic [3:0] disp_data;

    assign k        = cnt ^ {3{hflip_l}};
    assign pix      = data_l[{k, 2'b00} +: 4];
    assign colour   = prom[{pal_l, pix}];
    assign wr_x     = {1'b0, xpos_l} + {5'd0, half, cnt};
    assign draw_cur = bank_sel ? lbuf0[wr_x[7:0]] : lbuf1[wr_x[7:0]];
`ifdef JTPINPON_OBJ_KEEPFIRST_EN
    assign keep_ok  = (draw_cur == 4'd0);
`else
    assign keep_ok  = 1'b1;
`endif
    assign wr_en     = wr_pix && rst_n && !wr_x[8] && (colour != 4'd0) && keep_ok;
    assign rd_addr   = hdump[7:0] + HOFFSET;
    assign rd_en     = pxl_cen && LHBL;
    assign disp_data = bank_sel ? lbuf1[rd_addr] : lbuf0[rd_addr];

    // bank_sel=1: lbuf0 is drawn, lbuf1 displayed; each bank has a single write port
    always_ff @(posedge clk) begin
        if (bank_sel) begin
            if (wr_en) lbuf0[wr_x[7:0]] <= colour;
        end else if (rd_en) begin
            lbuf0[rd_addr] <= 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!bank_sel) begin
            if (wr_en) lbuf1[wr_x[7:0]] <= colour;
        end else if (rd_en) begin
            lbuf1[rd_addr] <= 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)       pxl <= 4'd0;
        else if (pxl_cen) pxl <= LHBL ? disp_data : 4'd0;
    end

endmodule
